// File: rtl/bsr_pkg.sv
// Shared definitions for the boundary scan register: instruction encodings
// and the register length derivation.
package bsr_pkg;

  typedef enum logic [1:0] {
    INSTR_BYPASS = 2'b00,
    INSTR_SAMPLE = 2'b01,
    INSTR_EXTEST = 2'b10,
    INSTR_INTEST = 2'b11
  } instr_e;

  // One control cell sits between the output and input cells.
  function automatic int unsigned bsr_len(input int unsigned nin, input int unsigned nout);
    return nin + nout + 1;
  endfunction

endpackage

// File: rtl/bsr_cell.sv
// Single boundary cell: a capture/shift flop feeding an update flop.
module bsr_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_pi,
  input  logic i_si,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  output logic o_so,
  output logic o_q
);

  logic r_sh;
  logic r_upd;

  // Capture wins over shift; update always takes the pre-edge shift value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_upd <= '0;
    end else begin
      if (i_capture)    r_sh <= i_pi;
      else if (i_shift) r_sh <= i_si;
      if (i_update)     r_upd <= r_sh;
    end
  end

  assign o_so = r_sh;
  assign o_q  = r_upd;

endmodule

// File: rtl/boundary_scan_reg.sv
// Boundary scan register: output cells at stage 0, then the control cell,
// then input cells; TDI enters the top stage and stage 0 drives TDO.
module boundary_scan_reg
  import bsr_pkg::*;
#(
  parameter int unsigned NUM_IN  = 34,
  parameter int unsigned NUM_OUT = 17
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               TDI,
  input  logic [1:0]         Instr,
  input  logic               CaptureDR,
  input  logic               ShiftDR,
  input  logic               UpdateDR,
  input  logic [NUM_IN-1:0]  sys_in,
  input  logic [NUM_OUT-1:0] core_out,
  input  logic               core_oe,
  output logic [NUM_IN-1:0]  core_in,
  output logic [NUM_OUT-1:0] sys_out,
  output logic               sys_oe,
  output logic               TDO
);

  localparam int unsigned L = bsr_len(NUM_IN, NUM_OUT);

  instr_e         w_instr;
  logic           w_bsr_sel;
  logic           w_cap;
  logic           w_shift;
  logic           w_update;
  logic [L-1:0]   w_pi;
  logic [L-1:0]   w_si;
  logic [L-1:0]   w_so;
  logic [L-1:0]   w_q;
  logic           r_bypass;

  assign w_instr   = instr_e'(Instr);
  assign w_bsr_sel = (w_instr != INSTR_BYPASS);
  assign w_cap     = CaptureDR & w_bsr_sel;
  assign w_shift   = ShiftDR   & w_bsr_sel;
  assign w_update  = UpdateDR  & w_bsr_sel;

  assign w_pi = {sys_in, core_oe, core_out};
  assign w_si = {TDI, w_so[L-1:1]};

  for (genvar g = 0; g < L; g++) begin : g_cell
    bsr_cell u_cell (
      .clk       (TCK),
      .rst       (TRST),
      .i_pi      (w_pi[g]),
      .i_si      (w_si[g]),
      .i_capture (w_cap),
      .i_shift   (w_shift),
      .i_update  (w_update),
      .o_so      (w_so[g]),
      .o_q       (w_q[g])
    );
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      r_bypass <= '0;
    end else if (!w_bsr_sel) begin
      if (CaptureDR)    r_bypass <= 1'b0;
      else if (ShiftDR) r_bypass <= TDI;
    end
  end

  always_comb begin
    TDO     = w_so[0];
    core_in = sys_in;
    sys_out = core_out;
    sys_oe  = core_oe;
    if (w_instr == INSTR_BYPASS) TDO = r_bypass;
    if (w_instr == INSTR_INTEST) core_in = w_q[L-1:NUM_OUT+1];
    if (w_instr == INSTR_EXTEST) begin
      sys_out = w_q[NUM_OUT-1:0];
      sys_oe  = w_q[NUM_OUT];
    end
  end

endmodule

// File: tb/tb_boundary_scan_reg.sv
// Scoreboard bench for boundary_scan_reg with default geometry (L = 52).
module tb_boundary_scan_reg;

  localparam int unsigned NI = 34;
  localparam int unsigned NO = 17;
  localparam int unsigned L  = NI + NO + 1;

  logic          TCK, TRST, TDI, CaptureDR, ShiftDR, UpdateDR, core_oe, sys_oe, TDO;
  logic [1:0]    Instr;
  logic [NI-1:0] sys_in, core_in;
  logic [NO-1:0] core_out, sys_out;

  logic [63:0]   exp_q[$];
  logic [L-1:0]  got, v;
  int unsigned   n_checks = 0;
  int unsigned   n_err    = 0;

  boundary_scan_reg #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI), .Instr(Instr),
    .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
    .sys_in(sys_in), .core_out(core_out), .core_oe(core_oe),
    .core_in(core_in), .sys_out(sys_out), .sys_oe(sys_oe), .TDO(TDO)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic c, input logic s, input logic u, input logic d);
    @(negedge TCK);
    CaptureDR = c; ShiftDR = s; UpdateDR = u; TDI = d;
    @(posedge TCK);
    #1;
    CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
  endtask

  // Shifts din in LSB-first while recording TDO ahead of each shift edge.
  task automatic scan(input logic [L-1:0] din, output logic [L-1:0] dout);
    for (int k = 0; k < int'(L); k++) begin
      @(negedge TCK);
      dout[k] = TDO;
      TDI = din[k];
      ShiftDR = 1'b1;
      @(posedge TCK);
    end
    #1;
    ShiftDR = 1'b0;
  endtask

  initial begin
    TRST = 1'b1; TDI = 1'b0; CaptureDR = 1'b0; ShiftDR = 1'b0; UpdateDR = 1'b0;
    Instr = 2'b10; sys_in = '0; core_out = 17'h1_5555; core_oe = 1'b1;
    #3;
    check_eq("rst_tdo", TDO, 0);
    check_eq("rst_sys_out", sys_out, 0);
    check_eq("rst_sys_oe", sys_oe, 0);
    Instr = 2'b11; #1;
    check_eq("rst_core_in", core_in, 0);
    @(negedge TCK);
    TRST = 1'b0;

    // BYPASS: capture 0, then TDI appears on TDO one edge later
    Instr = 2'b00;
    exp_q.push_back(64'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("byp_cap", TDO, exp_q.pop_front());
    v = '0;
    v[3:0] = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      core_out = 17'(k * 17'h0_3A5B + 1);
      exp_q.push_back(64'(v[k]));
      tick(1'b0, 1'b1, 1'b0, v[k]);
      check_eq("byp_tdo", TDO, exp_q.pop_front());
      check_eq("byp_sys_out", sys_out, core_out);
    end

    // SAMPLE_PRELOAD capture and full scan-out
    Instr = 2'b01; sys_in = 34'h2_AAAA_5555; core_out = 17'h1_0F0F; core_oe = 1'b1;
    exp_q.push_back(64'({sys_in, core_oe, core_out}));
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    scan('0, got);
    check_eq("sample_scan", got, exp_q.pop_front());

    // EXTEST: load and update output cells, pins then ignore core_out
    Instr = 2'b10;
    v = {34'h0, 1'b1, 17'h0_1234};
    scan(v, got);
    check_eq("ext_pre_upd", sys_out, 0);
    exp_q.push_back(64'h1234);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ext_sys_out", sys_out, exp_q.pop_front());
    check_eq("ext_sys_oe", sys_oe, 1);
    core_out = 17'h0_FFFF; core_oe = 1'b0; #1;
    check_eq("ext_hold", sys_out, 17'h0_1234);
    check_eq("ext_core_in", core_in, sys_in);

    // INTEST: input update cells drive the core regardless of sys_in
    Instr = 2'b11;
    v = {34'h3_FFFF_0000, 1'b0, 17'h0};
    scan(v, got);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      sys_in = {$urandom_range(3, 0), $urandom()};
      exp_q.push_back(64'h3_FFFF_0000);
      #1;
      check_eq("int_core_in", core_in, exp_q.pop_front());
    end
    check_eq("int_sys_out", sys_out, core_out);
    Instr = 2'b01; #0.1;
    check_eq("int_switch", core_in, sys_in);

    // Capture and shift together: capture only
    sys_in = 34'h1_2345_6789; core_out = 17'h0_ABCD; core_oe = 1'b0;
    exp_q.push_back(64'({sys_in, core_oe, core_out}));
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    scan('0, got);
    check_eq("cap_over_shift", got, exp_q.pop_front());

    // Update with shift: update sees the pre-shift contents
    Instr = 2'b10;
    v = {34'h0, 1'b1, 17'h1_2345};
    scan(v, got);
    exp_q.push_back(64'h1_2345);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("upd_shift_out", sys_out, exp_q.pop_front());
    check_eq("upd_shift_oe", sys_oe, 1);
    check_eq("upd_shift_tdo", TDO, v[1]);

    // Reset mid-shift at stage 25
    for (int k = 0; k < 25; k++) tick(1'b0, 1'b1, 1'b0, 1'b1);
    #1 TRST = 1'b1;
    #1;
    check_eq("mrst_tdo", TDO, 0);
    check_eq("mrst_sys_out", sys_out, 0);
    check_eq("mrst_sys_oe", sys_oe, 0);
    Instr = 2'b11; #0.5;
    check_eq("mrst_core_in", core_in, 0);
    #0.5 TRST = 1'b0;
    Instr = 2'b01;
    v = {34'h2_5A5A_A5A5, 1'b1, 17'h1_3C3C};
    exp_q.push_back(64'd0);
    scan(v, got);
    check_eq("mrst_clean", got, exp_q.pop_front());
    exp_q.push_back(64'(v));
    scan('0, got);
    check_eq("mrst_reload", got, exp_q.pop_front());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/boundary_scan_reg.md
BOUNDARY_SCAN_REG -- requirements
Module: boundary_scan_reg

Interface
REQ-001 Parameter NUM_IN, default 34, number of input boundary cells (system pin -> core).
REQ-002 Parameter NUM_OUT, default 17, number of output boundary cells (core -> system pin).
REQ-003 Derived constant L = NUM_IN + NUM_OUT + 1, boundary register length (one control cell).
REQ-004 Port TCK, in, 1, sole clock; all state changes on rising edge.
REQ-005 Port TRST, in, 1, asynchronous active-high reset.
REQ-006 Port TDI, in, 1, serial scan input.
REQ-007 Port Instr, in, 2, active instruction: 00 BYPASS, 01 SAMPLE_PRELOAD, 10 EXTEST, 11 INTEST.
REQ-008 Port CaptureDR / ShiftDR / UpdateDR, in, 1 each, DR operation enables sampled on TCK.
REQ-009 Port sys_in, in, NUM_IN, system pin inputs.
REQ-010 Port core_out, in, NUM_OUT, core outputs; core_oe, in, 1, core output enable.
REQ-011 Port core_in, out, NUM_IN, inputs presented to core.
REQ-012 Port sys_out, out, NUM_OUT, system pin outputs; sys_oe, out, 1, pin output enable.
REQ-013 Port TDO, out, 1, serial scan output.

Function
REQ-014 Shift stages: [0..NUM_OUT-1] output cells, [NUM_OUT] control cell, [NUM_OUT+1..L-1] input cells; TDI enters stage L-1, stage 0 drives TDO.
REQ-015 CaptureDR (non-BYPASS): input cells <- sys_in, output cells <- core_out, control cell <- core_oe, one edge.
REQ-016 ShiftDR (non-BYPASS): stage i <- stage i+1, stage L-1 <- TDI; L shifts required for a full load.
REQ-017 Priority within one edge: CaptureDR over ShiftDR; the losing operation is ignored.
REQ-018 UpdateDR (non-BYPASS): update register <- shift register contents present before that edge; simultaneous ShiftDR shifts as normal.
REQ-019 BYPASS: 1-bit bypass flop <- 0 on CaptureDR, <- TDI on ShiftDR; boundary shift and update registers hold; UpdateDR ignored.
REQ-020 TDO = bypass flop when Instr=BYPASS, else shift stage 0; combinational from flops, no TDI-to-TDO combinational path.
REQ-021 core_in = update input cells when Instr=INTEST, else sys_in.
REQ-022 sys_out = update output cells and sys_oe = update control cell when Instr=EXTEST, else core_out and core_oe.
REQ-023 Instr change is effective combinationally on muxes and on the next edge for register behaviour; no register cleared on instruction change.
REQ-024 No enable asserted: all registers hold.

Reset
REQ-025 TRST asserted: shift register, update register, bypass flop cleared to 0 immediately, regardless of TCK.
REQ-026 During reset: TDO=0; core_in, sys_out, sys_oe follow REQ-021/022 with update register = 0.
REQ-027 Reset mid-shift aborts shift; first edge after deassertion operates normally from all-zero state.

Structure
REQ-028 Package bsr_pkg holds the 2-bit instruction encodings and the L derivation.
REQ-029 One sub-module bsr_cell (capture/shift flop + update flop, capture/shift/update enables); L instances generated.

Verification (NUM_IN=34, NUM_OUT=17, L=52)
REQ-030 BYPASS, ShiftDR=1, TDI=1,0,1,1 -> TDO=0 (captured),1,0,1 one edge late; sys_out==core_out throughout.
REQ-031 SAMPLE_PRELOAD, sys_in=34'h2_AAAA_5555, core_out=17'h1_0F0F, core_oe=1, Capture then 52 shifts -> TDO LSB-first: 17'h1_0F0F, 1, 34'h2_AAAA_5555.
REQ-032 EXTEST, shift in pattern with outputs=17'h0_1234, ctl=1, UpdateDR -> sys_out=17'h0_1234, sys_oe=1 same edge onward; core_out changes do not reach pins.
REQ-033 INTEST, update input cells=34'h3_FFFF_0000 -> core_in=34'h3_FFFF_0000 while sys_in toggles; switch to SAMPLE_PRELOAD -> core_in==sys_in immediately.
REQ-034 CaptureDR and ShiftDR asserted together -> capture only, no shift; UpdateDR with ShiftDR -> update gets pre-shift value.
REQ-035 TRST pulse mid-shift (stage 25) -> all registers 0 without TCK edge, TDO=0, next 52 shifts clean.
